ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator for the team's dualPortRAM. The RAM has one synchronous write port and two combinational read ports.
- Converts a push/pop stream interface into RAM write and read addressing, and tracks full, empty and occupancy.
- Read port 1 presents the FIFO head, giving first-word fall-through. Read port 2 presents the entry behind the head, which downstream parsers use as a one-word lookahead.
- Storage lives entirely in the external RAM. This block holds pointers, counters and flags only.

Parameters:
- ADDR_WIDTH, 12, RAM address width. FIFO depth is 2^ADDR_WIDTH entries.
- DATA_WIDTH, 8, word width. Must match the RAM's DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request.
- wr_data  input  DATA_WIDTH  push data.
- rd_en  input  1  pop request.
- rd_data  output  DATA_WIDTH  head word, valid whenever empty=0.
- rd_data_next  output  DATA_WIDTH  word behind the head, valid whenever count>=2.
- next_valid  output  1  count>=2.
- full  output  1  count==2^ADDR_WIDTH.
- empty  output  1  count==0.
- count  output  ADDR_WIDTH+1  current occupancy.
- overflow  output  1  sticky; set when a push is rejected.
- underflow  output  1  sticky; set when a pop is rejected.
- clr_err  input  1  synchronous clear of overflow and underflow.
- ram_we  output  1  connects to RAM we.
- ram_write_addr  output  ADDR_WIDTH  connects to RAM write_addr.
- ram_write_data  output  DATA_WIDTH  connects to RAM write_data.
- ram_read_addr_1  output  ADDR_WIDTH  connects to RAM read_addr_1.
- ram_read_addr_2  output  ADDR_WIDTH  connects to RAM read_addr_2.
- ram_read_data_1  input  DATA_WIDTH  connects to RAM read_data_1.
- ram_read_data_2  input  DATA_WIDTH  connects to RAM read_data_2.

Behaviour:
- State:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - count is a registered counter.
  - overflow and underflow are registered.
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Consequently empty=1, full=0 and next_valid=0.
- Reset mid-operation discards all contents immediately. RAM contents are not cleared and are not visible afterwards because empty=1.
- Push acceptance: push_ok = wr_en & ~full. Pop acceptance: pop_ok = rd_en & ~empty.
- RAM write port, all combinational:
  - ram_we = push_ok.
  - ram_write_addr = wr_ptr[ADDR_WIDTH-1:0].
  - ram_write_data = wr_data.
  - The RAM captures the word on the same clock edge that advances wr_ptr.
- RAM read ports, all combinational:
  - ram_read_addr_1 = rd_ptr[ADDR_WIDTH-1:0], and rd_data = ram_read_data_1.
  - ram_read_addr_2 = rd_ptr[ADDR_WIDTH-1:0] + 1, modulo 2^ADDR_WIDTH, and rd_data_next = ram_read_data_2.
- Latency:
  - A pushed word is visible on rd_data the cycle after the push edge, when the FIFO was previously empty.
  - A pop advances the head at the edge; rd_data shows the new head in the following cycle.
- Pointer updates, per edge:
  - wr_ptr += push_ok.
  - rd_ptr += pop_ok.
  - Both pointers wrap naturally at 2^(ADDR_WIDTH+1).
- Count update: count += push_ok - pop_ok. When both are accepted, count is unchanged.
- Status flags: full is (wr_ptr ^ rd_ptr) == {1'b1, zeros}, and empty is wr_ptr == rd_ptr. Both must agree with count at all times.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted.
  - Empty: push only; the pop is rejected and underflow is set. There is no bypass.
  - Full: pop only; the push is rejected and overflow is set.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until clr_err=1 at an edge.
  - If clr_err and a new error occur in the same cycle, set wins.
- Rejected operations leave pointers, count and RAM contents unchanged. A rejected push drives ram_we=0.
- Address wrap: after 2^ADDR_WIDTH pushes the write address returns to 0; lookahead at head address max reads address 0.

Test Plan (bench uses ADDR_WIDTH=2, depth 4, DATA_WIDTH=8, instantiated with dualPortRAM):
- Reset, then idle -> empty=1, full=0, count=0, next_valid=0, ram_we=0, both error flags 0.
- Push 8'hA1, A2, A3, A4 on consecutive cycles -> count 1,2,3,4; full=1 after the 4th edge; rd_data=A1, rd_data_next=A2.
- While full, assert wr_en with 8'hFF -> ram_we=0, count stays 4, overflow=1. Then clr_err=1 for one cycle -> overflow=0.
- Pop four times -> rd_data sequence A1, A2, A3, A4; empty=1 after the last pop. Another rd_en -> underflow=1, rd_ptr unchanged.
- Wrap case: push B1..B3, pop 2, then push B4, B5 so the write address wraps past 3 -> pops return B3, B4, B5 in order; rd_data_next correct across the wrap.
- Simultaneous push and pop at count=2 -> count stays 2 and the head advances. Assert rst_n=0 mid-stream -> empty=1 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, count and flag controller that runs a FIFO inside an external dual-port RAM.
// Read port 1 is the first-word-fall-through head, and read port 2 is a one-word lookahead.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rd_data_next,
    output logic                  next_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_1,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_2,
    input  logic [DATA_WIDTH-1:0] ram_read_data_1,
    input  logic [DATA_WIDTH-1:0] ram_read_data_2
);
    localparam logic [ADDR_WIDTH:0]   WRAP  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                overflow_q, overflow_d, underflow_q, underflow_d;
    logic                push_ok, pop_ok;

    assign full            = (wr_ptr_q ^ rd_ptr_q) == WRAP;
    assign empty           = wr_ptr_q == rd_ptr_q;
    assign push_ok         = wr_en & ~full;
    assign pop_ok          = rd_en & ~empty;
    assign count           = count_q;
    assign next_valid      = count_q > C_ONE;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign ram_we          = push_ok;
    assign ram_write_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_write_data  = wr_data;
    assign ram_read_addr_1 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign ram_read_addr_2 = rd_ptr_q[ADDR_WIDTH-1:0] + A_ONE;
    assign rd_data         = ram_read_data_1;
    assign rd_data_next    = ram_read_data_2;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push_ok};
        rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop_ok};
        count_d     = count_q + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
        // a fresh error in the same cycle as clr_err keeps the flag set
        overflow_d  = (wr_en & full) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl at depth 4 with a behavioural dual-port RAM.
// A queue holds the expected FIFO contents and is compared against the head as words are popped.
module tb_ram_fifo_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk, rst_n, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data, rd_data, rd_data_next, ram_write_data, ram_read_data_1, ram_read_data_2;
    logic          next_valid, full, empty, overflow, underflow, ram_we;
    logic [AW:0]   count;
    logic [AW-1:0] ram_write_addr, ram_read_addr_1, ram_read_addr_2;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb [$];
    int            checks = 0;
    int            errors = 0;

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_data_next(rd_data_next), .next_valid(next_valid),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err), .ram_we(ram_we), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_addr_1(ram_read_addr_1),
        .ram_read_addr_2(ram_read_addr_2), .ram_read_data_1(ram_read_data_1),
        .ram_read_data_2(ram_read_data_2)
    );

    always @(posedge clk) if (ram_we) mem[ram_write_addr] <= ram_write_data;
    assign ram_read_data_1 = mem[ram_read_addr_1];
    assign ram_read_data_2 = mem[ram_read_addr_2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // applies the already-driven inputs for one edge and updates the expected contents
    task automatic tick();
        bit p, q;
        logic [DW-1:0] d;
        p = wr_en && sb.size() < DEPTH;
        q = rd_en && sb.size() != 0;
        d = wr_data;
        @(posedge clk);
        #1;
        if (q) void'(sb.pop_front());
        if (p) sb.push_back(d);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (next_valid !== 1'b0) begin errors++; $display("FAIL reset_next_valid: got %b expected 0", next_valid); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
            #1;
            checks++; if (ram_we !== 1'b1 || ram_write_addr !== 2'(i)) begin errors++; $display("FAIL fill_write_port: got we=%b addr=%0d expected we=1 addr=%0d", ram_we, ram_write_addr, i); end
            tick();
            checks++; if (count !== 3'(sb.size())) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, sb.size()); end
        end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_full: got full=%b empty=%b expected 1 0", full, empty); end
        checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL fill_head: got %h expected %h", rd_data, sb[0]); end
        checks++; if (rd_data_next !== sb[1] || next_valid !== 1'b1) begin errors++; $display("FAIL fill_next: got %h/%b expected %h/1", rd_data_next, next_valid, sb[1]); end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 8'hFF;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ovf_ram_we: got %b expected 0", ram_we); end
        tick();
        checks++; if (count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got count=%0d ovf=%b expected 4 1", count, overflow); end
        wr_en = 1'b1; clr_err = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        clr_err = 1'b1;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL ovf_head_kept: got %h expected %h", rd_data, sb[0]); end
    endtask

    task automatic test_drain();
        while (sb.size() != 0) begin
            checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL drain_head: got %h expected %h", rd_data, sb[0]); end
            if (sb.size() > 1) begin
                checks++; if (rd_data_next !== sb[1]) begin errors++; $display("FAIL drain_next: got %h expected %h", rd_data_next, sb[1]); end
            end
            rd_en = 1'b1;
            tick();
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0 || next_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d nv=%b expected 1 0 0", empty, count, next_valid); end
        rd_en = 1'b1;
        tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", underflow); end
        checks++; if (ram_read_addr_1 !== 2'd0 || count !== 3'd0) begin errors++; $display("FAIL udf_ptr_kept: got addr=%0d count=%0d expected 0 0", ram_read_addr_1, count); end
        clr_err = 1'b1;
        tick();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", underflow); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'hB1 + 8'(i);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL wrap_pop_head: got %h expected %h", rd_data, sb[0]); end
            rd_en = 1'b1;
            tick();
        end
        wr_en = 1'b1; wr_data = 8'hB4;
        tick();
        wr_en = 1'b1; wr_data = 8'hB5;
        #1;
        checks++; if (ram_write_addr !== 2'd0 || ram_we !== 1'b1) begin errors++; $display("FAIL wrap_write_addr: got addr=%0d we=%b expected 0 1", ram_write_addr, ram_we); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", count); end
        while (sb.size() != 0) begin
            checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL wrap_head: got %h expected %h", rd_data, sb[0]); end
            if (sb.size() > 1) begin
                checks++; if (rd_data_next !== sb[1] || next_valid !== 1'b1) begin errors++; $display("FAIL wrap_next: got %h/%b expected %h/1", rd_data_next, next_valid, sb[1]); end
            end
            if (ram_read_addr_1 == 2'd3) begin
                checks++; if (ram_read_addr_2 !== 2'd0) begin errors++; $display("FAIL wrap_lookahead_addr: got %0d expected 0", ram_read_addr_2); end
            end
            rd_en = 1'b1;
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC0;
        tick();
        checks++; if (count !== 3'd1 || underflow !== 1'b1) begin errors++; $display("FAIL b2b_empty_push_only: got count=%0d udf=%b expected 1 1", count, underflow); end
        checks++; if (rd_data !== sb[0]) begin errors++; $display("FAIL b2b_fwft: got %h expected %h", rd_data, sb[0]); end
        clr_err = 1'b1; wr_en = 1'b1; wr_data = 8'hC1;
        tick();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC2;
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", count); end
        checks++; if (rd_data !== sb[0] || rd_data_next !== sb[1]) begin errors++; $display("FAIL b2b_head: got %h/%h expected %h/%h", rd_data, rd_data_next, sb[0], sb[1]); end
        wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL async_reset: got empty=%b count=%0d full=%b expected 1 0 0", empty, count, full); end
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (empty !== 1'b1 || next_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got empty=%b nv=%b expected 1 0", empty, next_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
